// File: rtl/piso8_pkg.sv
// ----------------------------------------------------------------------------
// piso8_pkg
// Shared definitions for the piso8 parallel-in / serial-out converter:
//   state_t       - FSM state encoding (IDLE, SHIFT)
//   N_DEFAULT     - default parallel word width
//   cnt_width()   - width of the bit counter for a given word width
// Configuration macro used by the design: PISO8_PARITY_EN
// ----------------------------------------------------------------------------
package piso8_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam int N_DEFAULT = 8;

    // Room for N data bits plus an optional parity bit, with one spare code
    // so the count never has to wrap inside a frame.
    function automatic int cnt_width(input int n);
        return $clog2(n + 2);
    endfunction

endpackage

// File: rtl/piso8_bitcnt.sv
// ----------------------------------------------------------------------------
// piso8_bitcnt
// Bit position counter for a piso8 frame.
// Parameters:
//   W    - counter width
//   TERM - count value at which tc is asserted
// Ports:
//   clk  in  clock
//   rst  in  asynchronous reset, active-low
//   clr  in  return the count to zero (has priority over inc)
//   inc  in  advance the count by one (saturates at all-ones, never wraps)
//   cnt  out current count
//   tc   out terminal count: cnt == TERM
// ----------------------------------------------------------------------------
module piso8_bitcnt
    import piso8_pkg::*;
#(
    parameter int W    = cnt_width(N_DEFAULT),
    parameter int TERM = N_DEFAULT - 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt,
    output logic         tc
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != {W{1'b1}})) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tc = (cnt == W'(TERM));

endmodule

// File: rtl/piso8.sv
// ----------------------------------------------------------------------------
// piso8
// Parallel-in / serial-out converter with a ready/valid style input.
// A word is captured when en && ready; its bits appear on sout starting the
// following cycle, one per clock. A new word may be captured during the final
// bit of a frame, giving gap-free back-to-back frames.
// Parameters:
//   N          - parallel word width
//   MSB_FIRST  - 0: d[0] is sent first, 1: d[N-1] is sent first
// Configuration macro:
//   PISO8_PARITY_EN - when defined, an even-parity bit (XOR of d) is appended
//                     as the final frame bit; frame length becomes N+1.
// Ports:
//   clk        in  clock, rising edge
//   rst        in  asynchronous reset, active-low
//   en         in  parallel word valid
//   d          in  parallel word
//   ready      out word accepted this cycle (IDLE, or SHIFT on the last bit)
//   sout       out serial data bit (registered)
//   sout_valid out sout carries a frame bit (registered)
//   last       out sout is the final frame bit (registered)
//   busy       out frame in progress (registered)
// ----------------------------------------------------------------------------
module piso8
    import piso8_pkg::*;
#(
    parameter int N         = N_DEFAULT,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [N-1:0] d,
    output logic         ready,
    output logic         sout,
    output logic         sout_valid,
    output logic         last,
    output logic         busy
);

`ifdef PISO8_PARITY_EN
    localparam int F = N + 1;
`else
    localparam int F = N;
`endif
    localparam int CW   = cnt_width(N);
    // tc flags the bit just before the final one, so last can be registered
    // on the edge that moves onto the final bit.
    localparam int TERM = (F >= 2) ? F - 2 : 0;

    state_t        state;
    state_t        state_nxt;
    logic [F-1:0]  frame;
    logic [F-1:0]  sr;
    logic          capture;
    logic          advance;
    logic [CW-1:0] cnt;
    logic          tc;

    assign ready   = (state == IDLE) || last;
    assign capture = en && ready;
    assign advance = (state == SHIFT) && !last;

    // Frame in transmit order: frame[0] goes out first.
    always_comb begin
        frame = '0;
        for (int i = 0; i < N; i++) begin
            frame[i] = MSB_FIRST ? d[N-1-i] : d[i];
        end
`ifdef PISO8_PARITY_EN
        frame[N] = ^d;
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (capture) state_nxt = SHIFT;
            SHIFT:   if (last && !capture) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // sr holds the bits still to be sent after the one currently on sout.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sr         <= '0;
            sout       <= 1'b0;
            sout_valid <= 1'b0;
            last       <= 1'b0;
            busy       <= 1'b0;
        end else if (capture) begin
            sr         <= frame >> 1;
            sout       <= frame[0];
            sout_valid <= 1'b1;
            last       <= (F == 1);
            busy       <= 1'b1;
        end else if (advance) begin
            sr         <= sr >> 1;
            sout       <= sr[0];
            last       <= tc;
        end else if (state == SHIFT) begin
            sr         <= '0;
            sout       <= 1'b0;
            sout_valid <= 1'b0;
            last       <= 1'b0;
            busy       <= 1'b0;
        end
    end

    piso8_bitcnt #(
        .W    (CW),
        .TERM (TERM)
    ) u_bitcnt (
        .clk (clk),
        .rst (rst),
        .clr (capture),
        .inc (advance),
        .cnt (cnt),
        .tc  (tc)
    );

endmodule

// File: tb/tb_piso8.sv
// ----------------------------------------------------------------------------
// tb_piso8
// Bench for piso8. Two instances (LSB-first and MSB-first) share stimulus.
// Each is compared every cycle against a queue model: the queue holds the
// frame bits still to be shown, head = bit currently on sout.
// Honours PISO8_PARITY_EN the same way as the design.
// ----------------------------------------------------------------------------
module tb_piso8;

    localparam int N = 8;
`ifdef PISO8_PARITY_EN
    localparam int F   = N + 1;
    localparam bit PAR = 1'b1;
`else
    localparam int F   = N;
    localparam bit PAR = 1'b0;
`endif

    typedef bit bq_t[$];

    logic         clk = 1'b0;
    logic         rst;
    logic         en;
    logic [N-1:0] d;
    logic rdy0, so0, sv0, la0, bz0;
    logic rdy1, so1, sv1, la1, bz1;

    int    checks   = 0;
    int    failures = 0;
    string phase    = "init";
    bq_t   q0;
    bq_t   q1;
    int    tally_valid;
    int    tally_ones;
    int    tally_last;

    always #5 clk = ~clk;

    piso8 #(.N(N), .MSB_FIRST(1'b0)) dut0 (
        .clk(clk), .rst(rst), .en(en), .d(d), .ready(rdy0),
        .sout(so0), .sout_valid(sv0), .last(la0), .busy(bz0)
    );

    piso8 #(.N(N), .MSB_FIRST(1'b1)) dut1 (
        .clk(clk), .rst(rst), .en(en), .d(d), .ready(rdy1),
        .sout(so1), .sout_valid(sv1), .last(la1), .busy(bz1)
    );

    function automatic bq_t frame_bits(input logic [N-1:0] w, input bit msb);
        bq_t q;
        for (int i = 0; i < N; i++) q.push_back(msb ? w[N-1-i] : w[i]);
        if (PAR) q.push_back(^w);
        return q;
    endfunction

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all();
        chk({phase, " ready0"}, rdy0, q0.size() <= 1);
        chk({phase, " sout0"},  so0,  (q0.size() > 0) ? q0[0] : 1'b0);
        chk({phase, " valid0"}, sv0,  q0.size() > 0);
        chk({phase, " last0"},  la0,  q0.size() == 1);
        chk({phase, " busy0"},  bz0,  q0.size() > 0);
        chk({phase, " ready1"}, rdy1, q1.size() <= 1);
        chk({phase, " sout1"},  so1,  (q1.size() > 0) ? q1[0] : 1'b0);
        chk({phase, " valid1"}, sv1,  q1.size() > 0);
        chk({phase, " last1"},  la1,  q1.size() == 1);
        chk({phase, " busy1"},  bz1,  q1.size() > 0);
    endtask

    // One clock: model decides capture from pre-edge inputs, then outputs
    // are compared 1 time unit after the edge.
    task automatic cycle();
        bit cap;
        cap = rst && en && (q0.size() <= 1);
        @(posedge clk);
        if (q0.size() > 0) void'(q0.pop_front());
        if (q1.size() > 0) void'(q1.pop_front());
        if (cap) begin
            q0 = frame_bits(d, 1'b0);
            q1 = frame_bits(d, 1'b1);
        end
        #1;
        check_all();
        tally_valid += int'(sv0);
        tally_ones  += int'(so0);
        tally_last  += int'(la0);
    endtask

    task automatic clear_tally();
        tally_valid = 0;
        tally_ones  = 0;
        tally_last  = 0;
    endtask

    initial begin
        logic [N-1:0] got0;
        logic [N-1:0] got1;
        int           run;
        logic         la_f;
        logic         la_2f;

        rst = 1'b0;
        en  = 1'b0;
        d   = '0;
        clear_tally();

        // Reset state
        #12;
        phase = "reset";
        check_all();
        rst = 1'b1;

        // A5, both bit orders; capture on the first edge after release
        phase = "a5";
        en = 1'b1;
        d  = 8'hA5;
        cycle();
        en = 1'b0;
        for (int i = 0; i < N; i++) begin
            got0[i]     = so0;
            got1[N-1-i] = so1;
            if (i == N - 1) chk_int("a5 last at bit N", int'(la0), int'(!PAR));
            cycle();
        end
        chk_int("a5 lsb word", int'(got0), 8'hA5);
        chk_int("a5 msb word", int'(got1), 8'hA5);
`ifdef PISO8_PARITY_EN
        chk("a5 parity bit", so0, 1'b0);
        chk("a5 parity last", la0, 1'b1);
`endif
        repeat (2) cycle();

`ifdef PISO8_PARITY_EN
        phase = "par07";
        en = 1'b1;
        d  = 8'h07;
        cycle();
        en = 1'b0;
        repeat (N) cycle();
        chk("07 parity bit", so0, 1'b1);
        chk("07 parity last", la0, 1'b1);
        repeat (2) cycle();
`endif

        // Back-to-back 3C then C3
        phase = "b2b";
        en = 1'b1;
        d  = 8'h3C;
        cycle();
        d  = 8'hC3;
        run   = 0;
        la_f  = 1'b0;
        la_2f = 1'b0;
        for (int i = 0; i < 2 * F; i++) begin
            run += int'(sv0);
            if (i == F - 1)     la_f  = la0;
            if (i == 2 * F - 1) la_2f = la0;
            cycle();
            if (i == F - 1) en = 1'b0;
        end
        chk_int("b2b valid run", run, 2 * F);
        chk("b2b last at F", la_f, 1'b1);
        chk("b2b last at 2F", la_2f, 1'b1);
        chk("b2b idle after", sv0, 1'b0);
        repeat (2) cycle();

        // Busy rejection
        phase = "reject";
        clear_tally();
        en = 1'b1;
        d  = 8'h00;
        cycle();
        en = 1'b0;
        repeat (2) cycle();
        en = 1'b1;
        d  = 8'hFF;
        cycle();
        en = 1'b0;
        repeat (F + 2) cycle();
        chk_int("reject ones", tally_ones, 0);
        chk_int("reject valid count", tally_valid, F);
        chk_int("reject last count", tally_last, 1);

        // Reset abort at bit 4
        phase = "abort";
        en = 1'b1;
        d  = 8'hA5;
        cycle();
        en = 1'b0;
        repeat (3) cycle();
        chk("abort pre valid", sv0, 1'b1);
        #2;
        rst = 1'b0;
        #1;
        q0.delete();
        q1.delete();
        check_all();
        #3;
        rst = 1'b1;
        clear_tally();
        repeat (F + 2) cycle();
        chk_int("abort no bits", tally_valid, 0);

        // Random traffic
        phase = "rand";
        for (int i = 0; i < 400; i++) begin
            en = ($urandom_range(0, 3) != 0);
            d  = N'($urandom);
            cycle();
        end
        en = 1'b0;
        repeat (F + 2) cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
